signed_divider: RTL
===================

SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the quotient/divisor/remainder width (dividend is 2N).
REQ-002 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  the reset, asynchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-005 The block SHALL have port dividend  input  2N  two's-complement dividend, captured on accepted start.
REQ-006 The block SHALL have port divisor  input  N  two's-complement divisor, captured on accepted start.
REQ-007 The block SHALL have port quotient  output  N  two's-complement quotient, truncated toward zero.
REQ-008 The block SHALL have port remainder  output  N  two's-complement remainder, sign equal to dividend sign (or zero).
REQ-009 The block SHALL have port busy  output  1  high from the cycle after accept until done.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse when results are valid.
REQ-011 The block SHALL have port div_by_zero  output  1  divisor was zero, valid with done.
REQ-012 The block SHALL have port overflow  output  1  quotient not representable in N signed bits, valid with done.

Function
REQ-013 The block SHALL use FSM states IDLE, CHECK, ITER, FIX, DONE.
REQ-014 In IDLE, start=1 SHALL capture the operands, latch their signs, store the magnitudes (2N-bit dividend, N-bit divisor), and move to CHECK.
REQ-015 In CHECK, a zero divisor SHALL move to DONE with div_by_zero=1, quotient=0, and remainder=dividend[N-1:0].
REQ-016 In CHECK, an upper-half magnitude of at least the divisor magnitude SHALL move to DONE with overflow=1, quotient=0, and remainder=0.
REQ-017 Otherwise, CHECK SHALL clear the iteration counter and move to ITER.
REQ-018 In ITER, each cycle SHALL perform one restoring step:
  - shift the (N+1)-bit partial remainder left, bringing in the next dividend bit
  - trial-subtract the divisor magnitude
  - if non-negative, keep the result and shift in a quotient bit of 1; otherwise restore and shift in 0
REQ-019 ITER SHALL run exactly N cycles, with the counter wrapping from N-1 to FIX.
REQ-020 FIX SHALL negate the quotient magnitude when the operand signs differ, and negate the remainder magnitude when the dividend is negative.
REQ-021 FIX SHALL set overflow=1 (quotient and remainder forced to 0) when:
  - a positive quotient magnitude exceeds 2^(N-1)-1, or
  - a negative quotient magnitude exceeds 2^(N-1).
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 Latency SHALL be N+3 cycles from the accept edge to done (normal path) and 2 cycles on the div_by_zero or CHECK-overflow paths.
REQ-024 quotient, remainder, div_by_zero and overflow SHALL be registered and held stable from done until the next accepted start.
REQ-025 start while busy or in DONE SHALL be ignored with no queuing, and operand changes while busy SHALL have no effect.
REQ-026 A dividend of -2^(2N-1) SHALL be handled via the 2N-bit unsigned magnitude without loss.

Reset
REQ-027 rst=1 SHALL immediately force:
  - state IDLE
  - counter 0
  - busy=0, done=0, div_by_zero=0, overflow=0
  - quotient=0, remainder=0
REQ-028 Assertion of rst mid-operation SHALL abort the division with no done pulse, and the first start after rst deassertion SHALL be accepted normally.

Structure
REQ-029 A shared package divider_pkg SHALL hold the FSM state enum and the default width constant (8).
REQ-030 The combinational restoring step SHALL be a sub-module named div_step, with inputs partial remainder, next dividend bit and divisor, and outputs new partial remainder and quotient bit.

Verification
REQ-031 The bench SHALL cover: 100 / 7 -> quotient 14, remainder 2, done at accept+11, no flags.
REQ-032 The bench SHALL cover: -7 / 2 -> quotient -3 (8'hFD), remainder -1 (8'hFF); and 7 / -2 -> quotient -3, remainder 1.
REQ-033 The bench SHALL cover: 1000 / 3 -> overflow=1, quotient 0, remainder 0; 16'h8000 / -128 -> overflow=1 via CHECK at accept+2; -1024 / 8 -> quotient -128 (8'h80), remainder 0, no overflow.
REQ-034 The bench SHALL cover: 1234 / 0 -> div_by_zero=1, quotient 0, remainder 8'hD2, done at accept+2.
REQ-035 The bench SHALL cover: start re-pulsed with new operands during ITER -> ignored, and the original result is delivered.
REQ-036 The bench SHALL cover: rst asserted at iteration 4 -> all outputs 0 at once, no done, and the next start of 50 / 5 gives quotient 10.

Source files
------------

// File: rtl/divider_pkg.sv
// ============================================================================
// Module : divider_pkg
// Brief  : Shared FSM state encoding and default width for the signed divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ITER  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring-division step on unsigned magnitudes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   rem_in,
    input  logic         dvd_bit,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N+1:0] shifted;
    logic [N+1:0] diff;

    // The partial remainder stays below the divisor, so the shifted value never
    // reaches bit N+1; the top bit of the difference is therefore its sign.
    assign shifted = {rem_in, dvd_bit};
    assign diff    = shifted - {2'b00, divisor};
    assign q_bit   = ~diff[N+1];
    assign rem_out = q_bit ? diff[N:0] : shifted[N:0];

endmodule

`default_nettype wire

// File: rtl/signed_divider.sv
// ============================================================================
// Module : signed_divider
// Brief  : Sequential 2N/N two's-complement divider, restoring, one bit/cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module signed_divider
    import divider_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_t state, next_state;

    logic [CW-1:0]  cnt;
    logic           dvd_neg;
    logic           dvs_neg;
    logic [N-1:0]   dvs_mag;
    logic [N-1:0]   dvd_low_raw;
    logic [N:0]     prem;
    logic [N-1:0]   low_sr;
    logic [N-1:0]   qmag;

    logic [2*N-1:0] dvd_abs;
    logic [N-1:0]   dvs_abs;
    logic [N:0]     step_rem;
    logic           step_q;
    logic           q_neg;
    logic           q_ovf;

    // Negating the most negative value wraps to itself, which is the correct
    // unsigned magnitude at this width.
    assign dvd_abs = dividend[2*N-1] ? (~dividend + 1'b1) : dividend;
    assign dvs_abs = divisor[N-1]    ? (~divisor + 1'b1)  : divisor;

    assign q_neg = dvd_neg ^ dvs_neg;
    assign q_ovf = q_neg ? (qmag[N-1] & (|qmag[N-2:0])) : qmag[N-1];

    div_step #(.N(N)) u_step (
        .rem_in  (prem),
        .dvd_bit (low_sr[N-1]),
        .divisor (dvs_mag),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = CHECK;
            CHECK:   begin
                if ((dvs_mag == '0) || (prem[N-1:0] >= dvs_mag)) begin
                    next_state = DONE;
                end else begin
                    next_state = ITER;
                end
            end
            ITER:    if (cnt == LAST) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
            dvs_mag     <= '0;
            dvd_low_raw <= '0;
            prem        <= '0;
            low_sr      <= '0;
            qmag        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd_neg     <= dividend[2*N-1];
                        dvs_neg     <= divisor[N-1];
                        dvs_mag     <= dvs_abs;
                        dvd_low_raw <= dividend[N-1:0];
                        prem        <= {1'b0, dvd_abs[2*N-1:N]};
                        low_sr      <= dvd_abs[N-1:0];
                        busy        <= 1'b1;
                    end
                end
                CHECK: begin
                    cnt <= '0;
                    if (dvs_mag == '0) begin
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                        quotient    <= '0;
                        remainder   <= dvd_low_raw;
                    end else if (prem[N-1:0] >= dvs_mag) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b1;
                        quotient    <= '0;
                        remainder   <= '0;
                    end
                end
                ITER: begin
                    prem   <= step_rem;
                    qmag   <= {qmag[N-2:0], step_q};
                    low_sr <= {low_sr[N-2:0], 1'b0};
                    cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                FIX: begin
                    div_by_zero <= 1'b0;
                    if (q_ovf) begin
                        overflow  <= 1'b1;
                        quotient  <= '0;
                        remainder <= '0;
                    end else begin
                        overflow  <= 1'b0;
                        quotient  <= q_neg   ? (~qmag + 1'b1) : qmag;
                        remainder <= dvd_neg ? (~prem[N-1:0] + 1'b1) : prem[N-1:0];
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
